// File: rtl/val2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : val2_pkg
// Purpose  : Shared type definitions for the iterative Val2 shifter
//            (shift-type encodings, FSM states, special-case flags).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package val2_pkg;

    // Encoding matches instruction bits [6:5].
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Special cases recognised by the decoder.
    //   ZERO  : zero shift, result is Rm and carry is CPSR C
    //   OVER  : register LSL/LSR by more than the width, result and carry 0
    //   RRX   : rotate right extended, one single-bit step through carry
    //   ROT32 : register ROR by a non-zero multiple of the width
    typedef enum logic [2:0] {
        FL_NONE  = 3'd0,
        FL_ZERO  = 3'd1,
        FL_OVER  = 3'd2,
        FL_RRX   = 3'd3,
        FL_ROT32 = 3'd4
    } flag_t;

    localparam int C_OPERAND_W = 12;
    localparam int C_RS_AMT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/val2_decode.sv
`default_nettype none
// ============================================================================
// Module   : val2_decode
// Purpose  : Combinational decode of a shifter-operand request into the
//            starting value, shift type, remaining distance, special-case
//            flag and preset carry used by the iterative shifter.
// Ports    : i_imm, i_mem_en, i_reg_shift - operand mode select
//            i_operand   - instruction bits [11:0]
//            i_rm        - Rm value
//            i_rs_amt    - Rs[7:0], register-shift amount
//            i_c_in      - current CPSR C
//            o_seed      - value loaded into the shift register
//            o_type      - shift type applied each iteration
//            o_dist      - total distance to shift (0 = result is o_seed)
//            o_flag      - special-case flag
//            o_carry     - carry-out when no iteration overrides it
// Revision : 1.0 - initial release
// ============================================================================
module val2_decode
    import val2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DW    = $clog2(WIDTH + 1)
) (
    input  logic                   i_imm,
    input  logic                   i_mem_en,
    input  logic                   i_reg_shift,
    input  logic [C_OPERAND_W-1:0] i_operand,
    input  logic [WIDTH-1:0]       i_rm,
    input  logic [C_RS_AMT_W-1:0]  i_rs_amt,
    input  logic                   i_c_in,
    output logic [WIDTH-1:0]       o_seed,
    output shift_t                 o_type,
    output logic [DW-1:0]          o_dist,
    output flag_t                  o_flag,
    output logic                   o_carry
);

    localparam int                    LW          = $clog2(WIDTH);
    localparam logic [C_RS_AMT_W-1:0] C_WIDTH_AMT = C_RS_AMT_W'(WIDTH);
    localparam logic [DW-1:0]         C_FULL_DIST = DW'(WIDTH);

    logic [4:0] w_imm_amt;
    shift_t     w_type;

    assign w_imm_amt = i_operand[11:7];
    assign w_type    = shift_t'(i_operand[6:5]);

    always_comb begin
        o_seed  = i_rm;
        o_type  = w_type;
        o_dist  = '0;
        o_flag  = FL_NONE;
        o_carry = i_c_in;

        if (i_mem_en) begin
            o_seed = WIDTH'(i_operand);
        end else if (i_imm) begin
            // 8-bit immediate rotated right by twice the 4-bit rotate field.
            o_seed = WIDTH'(i_operand[7:0]);
            o_type = SH_ROR;
            o_dist = DW'({i_operand[11:8], 1'b0});
        end else if (!i_reg_shift) begin
            if (w_imm_amt != 5'd0) begin
                o_dist = DW'(w_imm_amt);
            end else begin
                // A zero immediate amount re-encodes LSR/ASR #32 and RRX.
                case (w_type)
                    SH_LSL: o_flag = FL_ZERO;
                    SH_LSR,
                    SH_ASR: o_dist = C_FULL_DIST;
                    SH_ROR: begin
                        o_flag = FL_RRX;
                        o_dist = DW'(1);
                    end
                    default: o_flag = FL_NONE;
                endcase
            end
        end else if (i_rs_amt == '0) begin
            o_flag = FL_ZERO;
        end else begin
            case (w_type)
                SH_LSL,
                SH_LSR: begin
                    if (i_rs_amt > C_WIDTH_AMT) begin
                        // Everything shifted out, including the carry bit.
                        o_flag  = FL_OVER;
                        o_seed  = '0;
                        o_carry = 1'b0;
                    end else begin
                        o_dist = DW'(i_rs_amt);
                    end
                end
                SH_ASR: begin
                    // Beyond the width an arithmetic shift is pure sign fill.
                    o_dist = (i_rs_amt >= C_WIDTH_AMT) ? C_FULL_DIST : DW'(i_rs_amt);
                end
                SH_ROR: begin
                    if (i_rs_amt[LW-1:0] == '0) begin
                        o_flag  = FL_ROT32;
                        o_carry = i_rm[WIDTH-1];
                    end else begin
                        o_dist = DW'(i_rs_amt[LW-1:0]);
                    end
                end
                default: o_flag = FL_NONE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/val2_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : val2_shift_unit
// Purpose  : Multi-cycle ARM shifter-operand (Val2) generator. Accepts one
//            request per handshake, shifts STEP bit positions per cycle and
//            holds Val2 plus the shifter carry-out until consumed.
// Ports    : clk, rst_n (sync, active-low), flush (sync abort)
//            in_valid/in_ready   - request handshake (ready only when idle)
//            I, mem_en, reg_shift, shifter_operand, val_Rm, val_Rs, c_in
//                                - request fields, sampled on accept only
//            out_valid/out_ready - result handshake
//            val2, c_out         - result, stable while out_valid is held
// Revision : 1.0 - initial release
// ============================================================================
module val2_shift_unit
    import val2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   I,
    input  logic                   mem_en,
    input  logic                   reg_shift,
    input  logic [C_OPERAND_W-1:0] shifter_operand,
    input  logic [WIDTH-1:0]       val_Rm,
    input  logic [WIDTH-1:0]       val_Rs,
    input  logic                   c_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       val2,
    output logic                   c_out
);

    localparam int            DW      = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] C_STEP  = DW'(STEP);
    localparam logic [DW-1:0] C_WIDTH = DW'(WIDTH);
    localparam logic [DW-1:0] C_ONE   = DW'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_val;
    logic             r_carry;
    logic [DW-1:0]    r_rem;
    shift_t           r_type;
    flag_t            r_flag;
    logic             r_fill;

    // ------------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------------
    state_t           w_state_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_dec_seed;
    shift_t           w_dec_type;
    logic [DW-1:0]    w_dec_dist;
    flag_t            w_dec_flag;
    logic             w_dec_carry;
    logic [DW-1:0]    w_k;
    logic [DW-1:0]    w_km1;
    logic [DW-1:0]    w_rem_nxt;
    logic [WIDTH-1:0] w_rsh;
    logic [WIDTH-1:0] w_lsh;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_carry;
    logic             w_unused_rs;

    // Only Rs[7:0] carries a shift amount.
    assign w_unused_rs = ^val_Rs[WIDTH-1:C_RS_AMT_W];

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_valid && in_ready && !flush;
    assign out_valid = (r_state == ST_DONE);
    assign val2      = r_val;
    assign c_out     = r_carry;

    val2_decode #(
        .WIDTH (WIDTH),
        .DW    (DW)
    ) u_decode (
        .i_imm       (I),
        .i_mem_en    (mem_en),
        .i_reg_shift (reg_shift),
        .i_operand   (shifter_operand),
        .i_rm        (val_Rm),
        .i_rs_amt    (val_Rs[C_RS_AMT_W-1:0]),
        .i_c_in      (c_in),
        .o_seed      (w_dec_seed),
        .o_type      (w_dec_type),
        .o_dist      (w_dec_dist),
        .o_flag      (w_dec_flag),
        .o_carry     (w_dec_carry)
    );

    // ------------------------------------------------------------------------
    // One iteration of the shifter: k = min(STEP, remaining) positions.
    // The carry is the last bit to leave the word, obtained by shifting one
    // position less than k and taking the edge bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_k          = (r_rem > C_STEP) ? C_STEP : r_rem;
        w_km1        = w_k - C_ONE;
        w_rem_nxt    = r_rem - w_k;
        w_rsh        = r_val >> w_km1;
        w_lsh        = r_val << w_km1;
        w_step_val   = r_val;
        w_step_carry = r_carry;

        if (r_flag == FL_RRX) begin
            w_step_val   = {r_fill, r_val[WIDTH-1:1]};
            w_step_carry = r_val[0];
        end else begin
            case (r_type)
                SH_LSL: begin
                    w_step_val   = r_val << w_k;
                    w_step_carry = w_lsh[WIDTH-1];
                end
                SH_LSR: begin
                    w_step_val   = r_val >> w_k;
                    w_step_carry = w_rsh[0];
                end
                SH_ASR: begin
                    w_step_val   = WIDTH'($signed(r_val) >>> w_k);
                    w_step_carry = w_rsh[0];
                end
                SH_ROR: begin
                    // k == WIDTH makes the left term a zero-distance shift,
                    // which still yields the correct full rotation.
                    w_step_val   = (r_val >> w_k) | (r_val << (C_WIDTH - w_k));
                    w_step_carry = w_rsh[0];
                end
                default: begin
                    w_step_val   = r_val;
                    w_step_carry = r_carry;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = (w_dec_dist == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_rem_nxt == '0) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_val   <= '0;
            r_carry <= 1'b0;
            r_rem   <= '0;
            r_type  <= SH_LSL;
            r_flag  <= FL_NONE;
            r_fill  <= 1'b0;
        end else if (flush) begin
            r_rem <= '0;
        end else if (w_accept) begin
            r_val   <= w_dec_seed;
            r_carry <= w_dec_carry;
            r_rem   <= w_dec_dist;
            r_type  <= w_dec_type;
            r_flag  <= w_dec_flag;
            r_fill  <= c_in;
        end else if (r_state == ST_SHIFT) begin
            r_val   <= w_step_val;
            r_carry <= w_step_carry;
            r_rem   <= w_rem_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_val2_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_val2_shift_unit
// Purpose  : Self-checking bench for val2_shift_unit. A driver issues
//            directed and random requests and pushes the reference result
//            into a queue; a monitor pops and compares when out_valid rises,
//            checks latency and stability under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_val2_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        imm;
    logic        mem_en;
    logic        reg_shift;
    logic [11:0] op;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val2;
    logic        c_out;

    typedef struct {
        logic [31:0] v;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   hold_cnt = 0;
    int   bp_pct   = 30;

    val2_shift_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .I               (imm),
        .mem_en          (mem_en),
        .reg_shift       (reg_shift),
        .shifter_operand (op),
        .val_Rm          (rm),
        .val_Rs          (rs),
        .c_in            (c_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .val2            (val2),
        .c_out           (c_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ARM shifter reference, computed with double-width arithmetic.
    function automatic void model(input bit i_b, input bit m_b, input bit r_b,
                                  input logic [11:0] o, input logic [31:0] a,
                                  input logic [31:0] s, input bit ci,
                                  output logic [31:0] v, output logic c, output int d);
        int                 amt;
        logic [1:0]         ty;
        logic [63:0]        x;
        logic signed [63:0] sx;
        v = a;
        c = ci;
        d = 0;
        if (m_b) begin
            v = {20'd0, o};
            return;
        end
        if (i_b) begin
            d = 2 * int'(o[11:8]);
            x = {24'd0, o[7:0], 24'd0, o[7:0]} >> d;
            v = x[31:0];
            if (d != 0) c = v[31];
            return;
        end
        ty = o[6:5];
        if (!r_b) begin
            amt = int'(o[11:7]);
            if (amt == 0) begin
                if (ty == 2'b00) return;
                if (ty == 2'b11) begin
                    v = {ci, a[31:1]};
                    c = a[0];
                    d = 1;
                    return;
                end
                amt = 32;
            end
        end else begin
            amt = int'(s[7:0]);
            if (amt == 0) return;
            if (ty == 2'b11) begin
                amt = amt % 32;
                if (amt == 0) begin
                    c = a[31];
                    return;
                end
            end else if (ty == 2'b10) begin
                if (amt > 32) amt = 32;
            end else if (amt > 32) begin
                v = 32'd0;
                c = 1'b0;
                return;
            end
        end
        d = amt;
        case (ty)
            2'b00: begin x = {32'd0, a} << amt; v = x[31:0]; c = x[32]; end
            2'b01: begin x = {a, 32'd0} >> amt; v = x[63:32]; c = x[31]; end
            2'b10: begin sx = $signed({a, 32'd0}) >>> amt; v = sx[63:32]; c = sx[31]; end
            default: begin x = {a, a} >> amt; v = x[31:0]; c = v[31]; end
        endcase
    endfunction

    // Waits for the unit to be idle, presents one request for one cycle and
    // scrambles the request fields afterwards.
    task automatic issue(input bit i_b, input bit m_b, input bit r_b,
                         input logic [11:0] o, input logic [31:0] a,
                         input logic [31:0] s, input bit ci, input bit push);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", w);
            return;
        end
        imm       = i_b;
        mem_en    = m_b;
        reg_shift = r_b;
        op        = o;
        rm        = a;
        rs        = s;
        c_in      = ci;
        in_valid  = 1'b1;
        if (push) begin
            model(i_b, m_b, r_b, o, a, s, ci, e.v, e.c, e.lat);
            e.lat = (e.lat == 0) ? 1 : 1 + (e.lat + STEP - 1) / STEP;
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        imm       = 1'($urandom);
        mem_en    = 1'($urandom);
        reg_shift = 1'($urandom);
        op        = 12'($urandom);
        rm        = $urandom;
        rs        = $urandom;
        c_in      = 1'($urandom);
    endtask

    // Monitor / consumer
    initial begin
        exp_t cur;
        bit   held;
        bit   rel_chk;
        held      = 1'b0;
        rel_chk   = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held      = 1'b0;
                rel_chk   = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (rel_chk) begin
                chk("release_in_ready", {31'd0, in_ready}, 32'd1);
                chk("release_out_valid", {31'd0, out_valid}, 32'd0);
                rel_chk = 1'b0;
            end
            if (out_valid) begin
                if (!held) begin
                    if (q.size() == 0) begin
                        chk("out_valid_without_request", {31'd0, out_valid}, 32'd0);
                    end else begin
                        cur  = q.pop_front();
                        held = 1'b1;
                        chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    end
                end
                if (held) begin
                    chk("val2", val2, cur.v);
                    chk("c_out", {31'd0, c_out}, {31'd0, cur.c});
                    chk("in_ready_while_done", {31'd0, in_ready}, 32'd0);
                end
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = ($urandom_range(0, 99) >= bp_pct);
                end
                if (out_ready && held) begin
                    held    = 1'b0;
                    rel_chk = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom);
            end
        end
    end

    // Driver
    initial begin
        int          mode;
        logic [11:0] ro;
        logic [31:0] ra;
        logic [31:0] rsv;
        logic [7:0]  amt8;
        int          w;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        imm       = 1'b0;
        mem_en    = 1'b0;
        reg_shift = 1'b0;
        op        = 12'd0;
        rm        = 32'd0;
        rs        = 32'd0;
        c_in      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_val2", val2, 32'd0);
        chk("reset_c_out", {31'd0, c_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases
        issue(1, 0, 0, 12'h4FF, 32'h1234_5678, 32'd0, 0, 1);           // imm rotate
        issue(1, 0, 0, 12'h0A5, 32'h1234_5678, 32'd0, 1, 1);           // imm rot 0
        issue(0, 0, 0, 12'h020, 32'h8000_0001, 32'd0, 0, 1);           // LSR #0
        issue(0, 0, 0, 12'h040, 32'h8000_0001, 32'd0, 0, 1);           // ASR #0
        issue(0, 0, 0, 12'h060, 32'h0000_0003, 32'd0, 1, 1);           // RRX
        issue(0, 0, 0, 12'h000, 32'hDEAD_BEEF, 32'd0, 1, 1);           // LSL #0
        issue(0, 0, 1, 12'h210, 32'hFFFF_FFFF, 32'd40, 0, 1);          // reg LSL 40
        issue(0, 0, 1, 12'h210, 32'hFFFF_FFFF, 32'd32, 0, 1);          // reg LSL 32
        issue(0, 0, 1, 12'h230, 32'h8000_0000, 32'd32, 0, 1);          // reg LSR 32
        issue(0, 0, 1, 12'h250, 32'h8000_0000, 32'd200, 0, 1);         // reg ASR >32
        issue(0, 0, 1, 12'h270, 32'h8765_4321, 32'd64, 0, 1);          // reg ROR 64
        issue(0, 0, 1, 12'h270, 32'h8765_4321, 32'h1234_5600, 1, 1);   // reg amt 0
        issue(1, 1, 0, 12'hABC, 32'hFFFF_FFFF, 32'd0, 1, 1);           // mem offset
        hold_cnt = 5;
        issue(0, 0, 0, 12'h240, 32'h8000_00F0, 32'd0, 0, 1);           // hold in DONE

        // Flush while idle: the presented request must not be taken.
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        mem_en   = 1'b1;
        op       = 12'h123;
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) @(negedge clk);

        // Flush mid-SHIFT on a long register ASR.
        issue(0, 0, 1, 12'h250, 32'h8000_1234, 32'd20, 0, 0);
        chk("flush_busy_in_ready", {31'd0, in_ready}, 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_shift_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_shift_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (10) @(negedge clk);

        // Reset mid-SHIFT.
        issue(0, 0, 1, 12'h250, 32'h8000_1234, 32'd20, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_val2", val2, 32'd0);
        chk("midreset_c_out", {31'd0, c_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            mode = $urandom_range(0, 3);
            ro   = 12'($urandom);
            ra   = $urandom;
            rsv  = $urandom;
            case (mode)
                0: issue(1'($urandom), 1, 1'($urandom), ro, ra, rsv, 1'($urandom), 1);
                1: issue(1, 0, 1'($urandom), ro, ra, rsv, 1'($urandom), 1);
                2: begin
                    if ($urandom_range(0, 3) == 0) ro[11:7] = 5'd0;
                    issue(0, 0, 0, ro, ra, rsv, 1'($urandom), 1);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: amt8 = 8'($urandom_range(0, 8));
                        1: amt8 = 8'($urandom_range(28, 36));
                        2: amt8 = 8'($urandom_range(0, 255));
                        default: amt8 = 8'(32 * $urandom_range(0, 7));
                    endcase
                    rsv[7:0] = amt8;
                    ro[4]    = 1'b1;
                    ro[7]    = 1'b0;
                    issue(0, 0, 1, ro, ra, rsv, 1'($urandom), 1);
                end
            endcase
        end

        // Drain
        w = 0;
        while ((q.size() != 0 || !in_ready) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/val2_shift_unit.md
# val2_shift_unit

Multi-cycle, parametrised successor to the combinational Val2 generator in the EXE stage. Accepts one shifter-operand request per handshake, covers immediate-rotate, immediate-shift, register-shift (Rs-controlled) and memory-offset modes, and returns Val2 plus the ARM shifter carry-out. The shift is performed iteratively at STEP bit positions per cycle, trading latency for area. The hazard unit stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: datapath width; ARM semantics below assume 32.
- `STEP`, 4: bit positions shifted per cycle, power of two, 1..WIDTH. STEP=WIDTH gives single-pass operation.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous abort from branch/flush logic.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit idle; can accept.
- `I` in 1: immediate operand.
- `mem_en` in 1: load/store offset mode; overrides `I`.
- `reg_shift` in 1: shift amount from `val_Rs[7:0]` (bit 4 of instruction); ignored when `I` or `mem_en`.
- `shifter_operand` in 12: instruction bits [11:0].
- `val_Rm` in WIDTH: Rm value.
- `val_Rs` in WIDTH: Rs value, register-shift mode only.
- `c_in` in 1: current CPSR C.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes result.
- `val2` out WIDTH: shifter result.
- `c_out` out 1: shifter carry-out.

## Operation
- States: IDLE, SHIFT, DONE. Accept = `in_valid & in_ready`; `in_ready` = (state==IDLE).
- On accept, decode distance d, type, seed value, and special flags; latch them.
- mem_en: val2={20'd0,operand}, c_out=c_in, d=0.
- I: seed={24'd0,operand[7:0]}, ROR, d=2*operand[11:8]; c_out=c_in if d==0 else final val2[31].
- Immediate shift, amt=operand[11:7], type=operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR):
  - LSL #0: val2=Rm, c_out=c_in.
  - LSR #0 ≡ LSR #32: val2=0, c_out=Rm[31].
  - ASR #0 ≡ ASR #32: all bits Rm[31], c_out=Rm[31].
  - ROR #0 ≡ RRX: {c_in,Rm[31:1]}, c_out=Rm[0]; one-cycle SHIFT.
  - Otherwise d=amt; c_out = last bit shifted out.
- Register shift, amt=Rs[7:0]:
  - amt==0: val2=Rm, c_out=c_in.
  - LSL/LSR amt==32: val2=0, c_out=Rm[0]/Rm[31]. amt>32: val2=0, c_out=0; no iteration (d=0).
  - ASR amt≥32: sign fill, c_out=Rm[31], d clamped to 32.
  - ROR: d=amt[4:0]; if amt≠0 and d==0: val2=Rm, c_out=Rm[31].
- SHIFT: each cycle shift by k=min(STEP, remaining), capture c_out as last bit shifted out, remaining-=k. At remaining==0 → DONE.
- IDLE→DONE directly when d==0. DONE holds val2/c_out stable until `out_ready`, then → IDLE.

## Timing
- Reset (rst_n=0 at edge): state=IDLE, out_valid=0, val2=0, c_out=0, remaining=0; in_ready=1 the following cycle.
- Accept at edge T: out_valid rises after T+1 for d=0, after T+1+ceil(d/STEP) otherwise.
- No accept while in SHIFT or DONE; an accept cannot occur in the same cycle as DONE→IDLE. Peak throughput is one result per 2 cycles (d=0).
- Backpressure: out_valid=1 and out_ready=0 → val2, c_out and state frozen.
- Priority: rst_n > flush > handshake. flush in any state → IDLE next edge, out_valid=0, and the in-flight result is discarded; an in_valid in the flush cycle is not accepted.
- Inputs are sampled only on the accept edge; later changes are ignored.

## Structure
- Package `val2_pkg`: shift-type encodings (LSL/LSR/ASR/ROR), state enum, special-case flag enum (NONE, ZERO, OVER, RRX, ROT32).
- Sub-module `val2_decode`: combinational operand decode yielding seed, type, d, special flag, and preset carry. The top level holds the FSM and the iterative shifter.

## Test plan
- I=1, operand=12'h4FF, STEP=1 → val2=32'hFF000000, c_out=1, out_valid after 1+8 cycles; STEP=32 → 2 cycles.
- Imm LSR #0, Rm=32'h80000001 → val2=0, c_out=1; RRX with c_in=1, Rm=32'h00000003 → 32'h80000001, c_out=1.
- Reg LSL, Rs=40, Rm=32'hFFFFFFFF → val2=0, c_out=0, d=0 latency; Rs=32 → val2=0, c_out=1.
- mem_en=1, operand=12'hABC, I=1 → val2=32'h00000ABC, c_out=c_in, latency 1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0; release → IDLE next edge.
- flush mid-SHIFT (Reg ASR, Rs=20, STEP=1) → IDLE next edge, out_valid never asserted; rst_n=0 mid-SHIFT → all outputs at reset values.
